// File: rtl/priority_grant_fsm.sv
// -----------------------------------------------------------------------------
// priority_grant_fsm
//
// Sequential grant stage placed after a fixed-priority request encoder.
// When the stage is idle it picks the highest-index active request. It
// registers that request as a one-hot grant and holds it until one of two
// things happens: the owner releases (or drops its request), or the hold
// limit is reached. After every grant there is exactly one cool-down cycle,
// and then arbitration starts again.
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       synchronous, active-high reset
//   req_i         [N-1:0] level-held request vector, bit N-1 = highest priority
//   release_i     owner ends its grant (only looked at while granting)
//   gnt_o         [N-1:0] registered one-hot grant, zero when there is no owner
//   gnt_valid_o   high whenever gnt_o != 0
//   gnt_idx_o     [IDX_W-1:0] binary index of the granted bit, 0 when idle
//   timeout_o     one-cycle pulse when the hold limit revokes a grant
//   state_o       [1:0] current FSM state (IDLE=0, GRANT=1, COOL=2)
//
// Handshake: a requester holds its req bit high for as long as it wants the
// resource. The grant appears one cycle after the request is sampled. The
// owner returns the grant by pulsing release_i or by dropping its req bit.
// In both cases gnt_o clears at the next edge.
// -----------------------------------------------------------------------------
module priority_grant_fsm #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 15,
   parameter int CNT_W    = 4,
   parameter int IDX_W    = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [N-1:0]     req_i,
   input  logic             release_i,
   output logic [N-1:0]     gnt_o,
   output logic             gnt_valid_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             timeout_o,
   output logic [1:0]       state_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_COOL  = 2'd2;

   localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
   localparam logic [N-1:0]     ONE_HOT0   = N'(1);

   // Reject parameter sets where the counter cannot reach MAX_HOLD, and sets
   // where the index width does not match the number of requesters.
   if (MAX_HOLD < 1 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_hold
      $error("priority_grant_fsm: MAX_HOLD out of range for CNT_W");
   end
   if (IDX_W != $clog2(N)) begin : g_bad_idx
      $error("priority_grant_fsm: IDX_W must equal clog2(N)");
   end

   logic [1:0]       state_q,   state_d;
   logic [N-1:0]     gnt_q,     gnt_d;
   logic             valid_q,   valid_d;
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             timeout_q, timeout_d;

   logic [IDX_W-1:0] win_idx;
   logic             win_any;

   // Highest-index set bit wins. Later loop iterations override earlier
   // ones, which gives the higher bits priority.
   always_comb begin
      win_idx = '0;
      win_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req_i[i]) begin
            win_idx = IDX_W'(i);
            win_any = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      valid_d   = valid_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_any) begin
               gnt_d   = ONE_HOT0 << win_idx;
               idx_d   = win_idx;
               valid_d = 1'b1;
               cnt_d   = CNT_W'(1);
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // A voluntary end (release or a dropped request) is checked
            // before the hold limit, so it never produces a timeout pulse.
            if (release_i || !req_i[idx_q]) begin
               gnt_d   = '0;
               idx_d   = '0;
               valid_d = 1'b0;
               cnt_d   = '0;
               state_d = ST_COOL;
            end else if (cnt_q == HOLD_LIMIT) begin
               gnt_d     = '0;
               idx_d     = '0;
               valid_d   = 1'b0;
               cnt_d     = '0;
               timeout_d = 1'b1;
               state_d   = ST_COOL;
            end else begin
               // The counter stays below HOLD_LIMIT here, so it cannot wrap.
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_COOL: begin
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_valid_o = valid_q;
   assign gnt_idx_o   = idx_q;
   assign timeout_o   = timeout_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_priority_grant_fsm.sv
// -----------------------------------------------------------------------------
// tb_priority_grant_fsm
//
// Directed bench for priority_grant_fsm. A table of per-cycle vectors gives
// the inputs to apply before an edge and the outputs expected after it. Two
// hand-written sequences cover the hold-limit timeout and the case where a
// release lands on the same edge as the limit.
// -----------------------------------------------------------------------------
module tb_priority_grant_fsm;

   localparam int N        = 4;
   localparam int MAX_HOLD = 15;
   localparam int CNT_W    = 4;
   localparam int IDX_W    = 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_COOL  = 2'd2;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req;
   logic             rel;
   logic [N-1:0]     gnt;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;
   logic             timeout;
   logic [1:0]       state;

   always #5 clk = ~clk;

   priority_grant_fsm #(
      .N(N), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W), .IDX_W(IDX_W)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_i       (req),
      .release_i   (rel),
      .gnt_o       (gnt),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx),
      .timeout_o   (timeout),
      .state_o     (state)
   );

   // ---------------- scoreboard ----------------
   // Observed word layout: {gnt[3:0], gnt_valid, gnt_idx[1:0], timeout, state[1:0]}
   localparam int OW = 10;
   int n_checks = 0;
   int n_pass   = 0;

   logic [OW-1:0] exp_q[$];

   function automatic logic [OW-1:0] pack_exp(logic [N-1:0] g, logic [IDX_W-1:0] ix,
                                              logic to, logic [1:0] st);
      return {g, (g != '0), ix, to, st};
   endfunction

   task automatic check_now(input string name);
      logic [OW-1:0] act;
      logic [OW-1:0] exp;
      act = {gnt, gnt_valid, gnt_idx, timeout, state};
      exp = exp_q.pop_front();
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got gnt=%b valid=%b idx=%0d timeout=%b state=%0d, want gnt=%b valid=%b idx=%0d timeout=%b state=%0d",
                    name, act[9:6], act[5], act[4:3], act[2], act[1:0],
                    exp[9:6], exp[5], exp[4:3], exp[2], exp[1:0]);
   endtask

   // ---------------- driver ----------------
   // Inputs change 1 time unit after the rising edge. Outputs are sampled at
   // the same point, so nothing happens near the active edge.
   task automatic drive(input logic r, input logic [N-1:0] q, input logic rl);
      reset = r;
      req   = q;
      rel   = rl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string            name;
      logic             rst;
      logic [N-1:0]     req;
      logic             rel;
      logic [N-1:0]     e_gnt;
      logic [IDX_W-1:0] e_idx;
      logic             e_to;
      logic [1:0]       e_st;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(string nm, logic rs, logic [N-1:0] q, logic rl,
                               logic [N-1:0] g, logic [IDX_W-1:0] ix, logic to,
                               logic [1:0] st);
      vec_t v;
      v.name = nm; v.rst = rs; v.req = q; v.rel = rl;
      v.e_gnt = g; v.e_idx = ix; v.e_to = to; v.e_st = st;
      vecs.push_back(v);
   endfunction

   initial begin
      drive(1'b1, '0, 1'b0);

      // reset state
      add("reset",            1, 4'b0000, 0, 4'b0000, 0, 0, S_IDLE);
      add("idle_no_req",      0, 4'b0000, 0, 4'b0000, 0, 0, S_IDLE);
      // 0110: bit 2 wins. Release after three grant cycles, then a regrant.
      add("t1_grant",         0, 4'b0110, 0, 4'b0100, 2, 0, S_GRANT);
      add("t1_hold2",         0, 4'b0110, 0, 4'b0100, 2, 0, S_GRANT);
      add("t1_hold3",         0, 4'b0110, 0, 4'b0100, 2, 0, S_GRANT);
      add("t1_release",       0, 4'b0110, 1, 4'b0000, 0, 0, S_COOL);
      add("t1_cool_to_idle",  0, 4'b0110, 0, 4'b0000, 0, 0, S_IDLE);
      add("t1_regrant",       0, 4'b0110, 0, 4'b0100, 2, 0, S_GRANT);
      add("t1_release2",      0, 4'b0110, 1, 4'b0000, 0, 0, S_COOL);
      add("t1_idle",          0, 4'b0000, 0, 4'b0000, 0, 0, S_IDLE);
      // No preemption: the owner 0001 keeps the grant while 1000 waits.
      add("t2_grant_low",     0, 4'b0001, 0, 4'b0001, 0, 0, S_GRANT);
      add("t2_no_preempt1",   0, 4'b1001, 0, 4'b0001, 0, 0, S_GRANT);
      add("t2_no_preempt2",   0, 4'b1001, 0, 4'b0001, 0, 0, S_GRANT);
      add("t2_release",       0, 4'b1001, 1, 4'b0000, 0, 0, S_COOL);
      add("t2_cool_ignores",  0, 4'b1001, 0, 4'b0000, 0, 0, S_IDLE);
      add("t2_grant_high",    0, 4'b1001, 0, 4'b1000, 3, 0, S_GRANT);
      add("t2_owner_drop",    0, 4'b0001, 0, 4'b0000, 0, 0, S_COOL);
      add("t2_idle",          0, 4'b0000, 0, 4'b0000, 0, 0, S_IDLE);
      // The owner drops its request mid-grant: no timeout pulse.
      add("t4_grant",         0, 4'b0100, 0, 4'b0100, 2, 0, S_GRANT);
      add("t4_drop",          0, 4'b0000, 0, 4'b0000, 0, 0, S_COOL);
      add("t4_idle",          0, 4'b0000, 0, 4'b0000, 0, 0, S_IDLE);
      // release is ignored in IDLE and COOL.
      add("rel_idle_noreq",   0, 4'b0000, 1, 4'b0000, 0, 0, S_IDLE);
      add("rel_idle_grant",   0, 4'b0010, 1, 4'b0010, 1, 0, S_GRANT);
      add("rel_grant",        0, 4'b0010, 1, 4'b0000, 0, 0, S_COOL);
      add("rel_cool",         0, 4'b0010, 1, 4'b0000, 0, 0, S_IDLE);
      add("rel_idle_end",     0, 4'b0000, 0, 4'b0000, 0, 0, S_IDLE);
      // Reset mid-grant, then a regrant one cycle after reset is released.
      add("t6_grant",         0, 4'b1000, 0, 4'b1000, 3, 0, S_GRANT);
      add("t6_hold",          0, 4'b1000, 0, 4'b1000, 3, 0, S_GRANT);
      add("t6_reset",         1, 4'b1000, 0, 4'b0000, 0, 0, S_IDLE);
      add("t6_regrant",       0, 4'b1000, 0, 4'b1000, 3, 0, S_GRANT);
      add("t6_release",       0, 4'b1000, 1, 4'b0000, 0, 0, S_COOL);
      add("t6_idle",          0, 4'b0000, 0, 4'b0000, 0, 0, S_IDLE);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].req, vecs[i].rel);
         exp_q.push_back(pack_exp(vecs[i].e_gnt, vecs[i].e_idx, vecs[i].e_to, vecs[i].e_st));
         step();
         check_now(vecs[i].name);
      end

      // ---- hand-written: the hold limit revokes 0010 after MAX_HOLD cycles ----
      drive(1'b0, 4'b0010, 1'b0);
      for (int c = 1; c <= MAX_HOLD; c++) begin
         exp_q.push_back(pack_exp(4'b0010, 2'd1, 1'b0, S_GRANT));
         step();
         check_now($sformatf("to_hold_c%0d", c));
      end
      exp_q.push_back(pack_exp(4'b0000, 2'd0, 1'b1, S_COOL));
      step();
      check_now("to_revoke_pulse");
      exp_q.push_back(pack_exp(4'b0000, 2'd0, 1'b0, S_IDLE));
      step();
      check_now("to_pulse_one_cycle");
      // The same requester wins again straight after COOL.
      exp_q.push_back(pack_exp(4'b0010, 2'd1, 1'b0, S_GRANT));
      step();
      check_now("to_same_winner");

      // ---- hand-written: release on the edge where the counter hits MAX_HOLD ----
      for (int c = 2; c <= MAX_HOLD; c++) begin
         exp_q.push_back(pack_exp(4'b0010, 2'd1, 1'b0, S_GRANT));
         step();
         check_now($sformatf("rl_hold_c%0d", c));
      end
      drive(1'b0, 4'b0010, 1'b1);
      exp_q.push_back(pack_exp(4'b0000, 2'd0, 1'b0, S_COOL));
      step();
      check_now("rl_release_beats_timeout");
      drive(1'b0, 4'b0000, 1'b0);
      exp_q.push_back(pack_exp(4'b0000, 2'd0, 1'b0, S_IDLE));
      step();
      check_now("rl_idle");

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
